// File: rtl/bsc_scan_seq.sv
// bsc_scan_seq: capture/shift/update sequencer for a virtual boundary-scan chain.
// Optional compare logic (exp/mask/mismatch) is built when BSC_SEQ_CHECK_EN is defined.
module bsc_scan_seq #(
    parameter int VBSC_NUM    = 4,
    parameter int VBSC_NBIT   = 3,
    parameter int POLL_PERIOD = 1024,
    localparam int CHAIN_LEN  = VBSC_NUM * VBSC_NBIT
) (
    input  logic                 tck,
    input  logic                 rst,
    input  logic                 req,
    input  logic [CHAIN_LEN-1:0] wdata,
    input  logic                 tdo,
`ifdef BSC_SEQ_CHECK_EN
    input  logic [CHAIN_LEN-1:0] exp,
    input  logic [CHAIN_LEN-1:0] mask,
    output logic                 mismatch,
`endif
    output logic                 req_ack,
    output logic                 busy,
    output logic                 done,
    output logic                 done_src,
    output logic [CHAIN_LEN-1:0] rdata,
    output logic                 vjtag_cdr,
    output logic                 vjtag_sdr,
    output logic                 vjtag_udr,
    output logic                 tdi
);

    localparam int SCW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

    // Per-cell reset pattern: outj=0, oej=1, inj=0.
    localparam logic [VBSC_NBIT-1:0] CELL_RST = VBSC_NBIT'(2);
    localparam logic [CHAIN_LEN-1:0] SHD_RST  = {VBSC_NUM{CELL_RST}};

    typedef enum logic [2:0] {
        IDLE,
        CDR,
        SDR,
        GAP,
        UDR,
        DONE
    } state_t;

    state_t               state;
    logic [SCW-1:0]       sc;
    logic [CHAIN_LEN-1:0] sr;
    logic [CHAIN_LEN-1:0] shd;
    logic [CHAIN_LEN-1:0] rdata_nxt;
    logic                 poll_pend;
    logic                 poll_wrap;

    generate
        if (POLL_PERIOD > 0) begin : g_poll
            localparam int PCW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

            logic [PCW-1:0] pc;

            assign poll_wrap = (pc == PCW'(POLL_PERIOD - 1));

            // Free-running poll interval counter.
            always_ff @(posedge tck) begin
                if (rst) begin
                    pc <= '0;
                end else if (poll_wrap) begin
                    pc <= '0;
                end else begin
                    pc <= pc + PCW'(1);
                end
            end
        end else begin : g_nopoll
            assign poll_wrap = 1'b0;
        end
    endgenerate

    // Scan sequencer with registered strobes; a poll wrap wins over its own consumption.
    always_ff @(posedge tck) begin
        if (rst) begin
            state     <= IDLE;
            sc        <= '0;
            sr        <= '0;
            shd       <= SHD_RST;
            rdata_nxt <= '0;
            rdata     <= '0;
            poll_pend <= 1'b0;
            req_ack   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            done_src  <= 1'b0;
            vjtag_cdr <= 1'b0;
            vjtag_sdr <= 1'b0;
            vjtag_udr <= 1'b0;
            tdi       <= 1'b0;
`ifdef BSC_SEQ_CHECK_EN
            mismatch  <= 1'b0;
`endif
        end else begin
            req_ack <= 1'b0;
            done    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        sr        <= wdata;
                        shd       <= wdata;
                        done_src  <= 1'b0;
                        req_ack   <= 1'b1;
                        busy      <= 1'b1;
                        vjtag_cdr <= 1'b1;
                        state     <= CDR;
                    end else if (poll_pend) begin
                        sr        <= shd;
                        done_src  <= 1'b1;
                        poll_pend <= 1'b0;
                        busy      <= 1'b1;
                        vjtag_cdr <= 1'b1;
                        state     <= CDR;
                    end
                end
                CDR: begin
                    vjtag_cdr <= 1'b0;
                    vjtag_sdr <= 1'b1;
                    sc        <= '0;
                    tdi       <= sr[0];
                    state     <= SDR;
                end
                SDR: begin
                    sr            <= sr >> 1;
                    rdata_nxt[sc] <= tdo;
                    if (sc == SCW'(CHAIN_LEN - 1)) begin
                        vjtag_sdr <= 1'b0;
                        tdi       <= 1'b0;
                        state     <= GAP;
                    end else begin
                        sc  <= sc + SCW'(1);
                        tdi <= sr[1];
                    end
                end
                GAP: begin
                    vjtag_udr <= 1'b1;
                    state     <= UDR;
                end
                UDR: begin
                    vjtag_udr <= 1'b0;
                    state     <= DONE;
                end
                DONE: begin
                    rdata    <= rdata_nxt;
                    done     <= 1'b1;
                    busy     <= 1'b0;
`ifdef BSC_SEQ_CHECK_EN
                    mismatch <= |((rdata_nxt ^ exp) & mask);
`endif
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (poll_wrap) begin
                poll_pend <= 1'b1;
            end
        end
    end

endmodule

// File: doc/bsc_scan_seq.md
BSC_SCAN_SEQ -- requirements
Module: bsc_scan_seq

Interface
REQ-001 Parameter VBSC_NUM, default 4, is the number of virtual boundary-scan cells in the chain.
REQ-002 Parameter VBSC_NBIT, default 3, is the bits per cell, ordered inj (bit 0), oej (bit 1), outj (bit 2); CHAIN_LEN = VBSC_NUM*VBSC_NBIT (12).
REQ-003 Parameter POLL_PERIOD, default 1024, is the poll interval in tck cycles; 0 disables polling.
REQ-004 tck  in  1  single clock; every register samples on posedge tck.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req  in  1  host scan request, level, sampled only in IDLE.
REQ-007 wdata  in  CHAIN_LEN  host pattern, shifted LSB first; latched on acceptance.
REQ-008 req_ack  out  1  one-cycle pulse, host request accepted.
REQ-009 busy  out  1  high whenever state is not IDLE.
REQ-010 done  out  1  one-cycle pulse, scan complete, rdata valid.
REQ-011 done_src  out  1  0 = host scan, 1 = poll scan; valid with done, held afterwards.
REQ-012 rdata  out  CHAIN_LEN  captured chain bits; bit k is the tdo sample of shift cycle k; held until the next done.
REQ-013 vjtag_cdr, vjtag_sdr, vjtag_udr  out  1 each  capture, shift and update state strobes to the BSC chain.
REQ-014 tdi  out  1  serial data to the chain.
REQ-015 tdo  in  1  serial data from the chain, combinational on the chain side.

Function
REQ-016 The FSM states are IDLE, CDR, SDR, GAP, UDR, DONE; exactly one strobe is high, and only in its matching state (cdr in CDR, sdr in SDR, udr in UDR).
REQ-017 In IDLE with req=1, the next edge latches wdata into shift register sr and shadow register shd, sets done_src=0, pulses req_ack, and enters CDR.
REQ-018 In IDLE with req=0 and poll_pend=1, the next edge loads sr from shd, sets done_src=1, clears poll_pend, and enters CDR; no req_ack is pulsed.
REQ-019 Arbitration: when req and poll_pend are both high in IDLE, the host scan starts and poll_pend stays set for the following IDLE cycle.
REQ-020 CDR lasts 1 cycle, then the FSM enters SDR.
REQ-021 SDR lasts exactly CHAIN_LEN cycles, tracked by shift counter sc running 0..CHAIN_LEN-1.
REQ-022 In SDR, tdi = sr[0]; each edge shifts sr right by one and writes tdo into rdata_nxt[sc].
REQ-023 GAP lasts 1 cycle with all strobes low, so the chain loads its capture registers on the sdr falling edge.
REQ-024 UDR lasts 1 cycle; DONE lasts 1 cycle and transfers rdata_nxt to rdata with done=1; the FSM then returns to IDLE.
REQ-025 Latency: done is asserted exactly CHAIN_LEN+4 cycles after the req_ack cycle (16 cycles at the default parameters).
REQ-026 Poll counter pc increments every cycle and wraps at POLL_PERIOD-1; at the wrap it sets poll_pend.
REQ-027 A wrap while poll_pend is already set is absorbed: there is no queueing beyond one pending poll.
REQ-028 A poll scan re-shifts shd so the chain update leaves pin state unchanged.
REQ-029 When IDLE is entered from DONE, a pending request can be accepted in that same IDLE cycle, giving a one-cycle minimum gap between scans.
REQ-030 req is ignored while busy=1; wdata changes after acceptance have no effect on the scan in progress.

Reset
REQ-031 On rst=1 at an edge, every register takes its reset value at that edge, including mid-scan; the aborted scan produces no done.
REQ-032 Reset values: state=IDLE; all strobes, tdi, req_ack, done, busy, done_src, poll_pend and mismatch = 0; sc=0; pc=0; rdata=0.
REQ-033 Reset value of shd = one cell pattern {outj=0, oej=1, inj=0} per cell, i.e. 12'h492 at default parameters.

Configuration
REQ-034 With macro BSC_SEQ_CHECK_EN defined: inputs exp[CHAIN_LEN-1:0] and mask[CHAIN_LEN-1:0] and output mismatch exist, and mismatch is registered with done as |((rdata_nxt ^ exp) & mask) and held until the next done.
REQ-035 Without BSC_SEQ_CHECK_EN: the ports exp, mask and mismatch and their logic are absent, and all other behaviour is identical.

Verification
REQ-036 Reset, then req=1 with wdata=12'hA5C and tdo=1 -> req_ack 1 cycle later, sdr high for 12 cycles, tdi sequence 0,0,1,1,1,0,1,0,0,1,0,1, done 16 cycles after req_ack, rdata=12'hFFF, done_src=0.
REQ-037 POLL_PERIOD=32, no req -> the first poll scan enters CDR at cycle 33 with tdi pattern 12'h492, done_src=1, and repeats every 32 cycles.
REQ-038 req and poll_pend both high in IDLE -> the host scan runs first; the poll scan starts 1 cycle after that scan's done and shifts the new shd=wdata.
REQ-039 rst asserted on the 5th SDR cycle -> all strobes low, busy=0 and shd=12'h492 the next cycle; no done pulse occurs.
REQ-040 BSC_SEQ_CHECK_EN defined, tdo stream equal to 12'h0F0, exp=12'h0F1, mask=12'h00F -> mismatch=1 with done; with mask=12'hFF0 -> mismatch=0.
